// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Default geometry, zero-register address and read-port slice offsets.
package reg_file_pkg;

  localparam int DEF_W  = 5;
  localparam int DEF_B  = 32;
  localparam int DEF_NR = 2;

  localparam int ZERO_ADDR = 0;

  // Low bit of read port k inside a packed vector of per-port fields of width w.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: array row + busy bit, with write bypass and zero-register masking.
// Latency 0 (pure combinational); no backpressure, always accepts an address.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int B        = DEF_B,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         reset,
  input  logic [W-1:0] addr,
  input  logic [B-1:0] row,
  input  logic         busy_bit,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] data,
  output logic         busy
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0) && (addr == W'(ZERO_ADDR));
  assign hit     = (BYPASS != 0) && wr_en && (w_addr == addr);

  always_comb begin
    data = row;
    busy = busy_bit;
    if (reset || is_zero) begin
      data = '0;
      busy = 1'b0;
    end else if (hit) begin
      // An in-flight write is the producer completing, so it also clears busy.
      data = w_data;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with pending-write scoreboard and busy counter.
// Reads latency 0, writes/reserves land on the clock edge; no backpressure.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int B        = DEF_B,
  parameter int NR       = DEF_NR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NR*W-1:0] r_addr,
  output logic [NR*B-1:0] r_data,
  output logic [NR-1:0]   r_busy,
  input  logic            wr_en,
  input  logic [W-1:0]    w_addr,
  input  logic [B-1:0]    w_data,
  input  logic            rsv_en,
  input  logic [W-1:0]    rsv_addr,
  output logic [W:0]      busy_cnt
);

  localparam int N = 1 << W;

  logic [B-1:0] mem [N];
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_nxt;
  logic [W:0]   cnt_q;
  logic         w_ok;
  logic         r_ok;
  logic         inc;
  logic         dec;

  assign w_ok = wr_en  && !((ZERO_REG != 0) && (w_addr   == W'(ZERO_ADDR)));
  assign r_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == W'(ZERO_ADDR)));

  // Reserve is applied after the write-clear so a same-address reserve wins.
  always_comb begin
    busy_nxt = busy_q;
    if (w_ok) busy_nxt[w_addr] = 1'b0;
    if (r_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  assign inc = r_ok && !busy_q[rsv_addr];
  assign dec = w_ok && busy_q[w_addr] && !(r_ok && (rsv_addr == w_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_ok) mem[w_addr] <= w_data;
      busy_q <= busy_nxt;
      cnt_q  <= cnt_q + {{W{1'b0}}, inc} - {{W{1'b0}}, dec};
    end
  end

  assign busy_cnt = reset ? '0 : cnt_q;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [W-1:0] ra;
    assign ra = r_addr[slice_lo(k, W) +: W];

    reg_file_read_port #(
      .W(W), .B(B), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port (
      .reset   (reset),
      .addr    (ra),
      .row     (mem[ra]),
      .busy_bit(busy_q[ra]),
      .wr_en   (wr_en),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .data    (r_data[slice_lo(k, B) +: B]),
      .busy    (r_busy[k])
    );
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with write-to-read bypass, optional hard-wired zero register and a per-register pending-write scoreboard. It replaces the two-read/one-write integer register file in the pipelined core. Decode reads operands through it and receives a busy flag per operand. Issue reserves the destination register, and writeback clears the reservation.

## Interface
- W, 5, address bits; the file holds 2**W registers
- B, 32, bits per register
- NR, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- r_addr  in  NR*W  read addresses; port k occupies bits [k*W +: W]
- r_data  out  NR*B  read data; port k occupies bits [k*B +: B]
- r_busy  out  NR  1 = register at r_addr[k] has an outstanding reservation
- wr_en  in  1  write enable
- w_addr  in  W  write address
- w_data  in  B  write data
- rsv_en  in  1  reserve (mark pending) a destination register
- rsv_addr  in  W  address to reserve
- busy_cnt  out  W+1  number of registers currently reserved

## Operation
- State: array[0..2**W-1] of B bits; busy[0..2**W-1]; busy_cnt register.
- Write: when wr_en=1, array[w_addr] <= w_data at the clock edge. The write also clears busy[w_addr].
- Reserve: when rsv_en=1, busy[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the reserve wins, so busy stays 1 because a new producer has been issued. The array still takes w_data.
- Reserve to an address already busy: no change, and busy_cnt is not incremented.
- Write to a non-busy address: the data is written and busy_cnt is unchanged.
- ZERO_REG=1: writes and reserves to address 0 are ignored. r_data for address 0 is 0 and r_busy is 0.
- Read port k (combinational):
  - If BYPASS=1, wr_en=1, w_addr==r_addr[k], and the address is not the zero register, then r_data = w_data and r_busy = 0.
  - Otherwise r_data = array[r_addr[k]] and r_busy = busy[r_addr[k]].
- Ports are independent, and any number may address the same register.
- busy_cnt is updated every cycle:
  - +1 for a new reservation of a non-busy register.
  - −1 for a write that clears a busy register, unless the same address is reserved that cycle.
  - Both events on different addresses: net 0.
  - busy_cnt always equals the popcount of busy.

## Timing
- Reset: at the first rising edge with reset=1, all array entries go to 0, all busy bits go to 0 and busy_cnt goes to 0. Reset overrides wr_en and rsv_en.
- While reset=1: r_data=0, r_busy=0 and busy_cnt=0 on all ports. Bypass is disabled.
- Reset asserted mid-operation: pending reservations are discarded, and the write in that cycle is dropped.
- Read latency: 0 cycles (combinational from r_addr).
- Write visibility:
  - With BYPASS=1, a write is visible in the same cycle.
  - With BYPASS=0, it is visible from the cycle after the edge.
- Reserve visibility: r_busy rises in the cycle after the edge. It is never forwarded combinationally.
- Write-clear visibility:
  - With BYPASS=1, r_busy drops in the same cycle.
  - With BYPASS=0, it drops in the next cycle.
- No combinational path from rsv_* to any output.

## Structure
- Shared package reg_file_pkg:
  - default W/B/NR constants
  - ZERO_ADDR = 0
  - a function for read-port slice extraction
- Sub-module reg_file_read_port: one per read port, created by generate loop k=0..NR-1. It takes the address, the array row, the busy bit and the write-port signals, and produces r_data[k] and r_busy[k] including bypass and zero-register logic.
- The top level holds the array, the busy vector, the busy_cnt counter and the reset logic.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert reset for 1 cycle → all r_data=0, r_busy=0 and busy_cnt=0. A write issued in the reset cycle is not stored.
- Bypass, NR=3, BYPASS=1:
  - wr_en with w_addr=7, w_data=0x1234, and all three ports reading r7 → all ports show 0x1234 in the same cycle.
  - Repeat with BYPASS=0 → old value that cycle, 0x1234 next cycle.
- Zero register, ZERO_REG=1:
  - write 0xFFFFFFFF to r0 and reserve r0 → r_data=0, r_busy=0, busy_cnt=0.
  - With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- Scoreboard sequence:
  - reserve r3, then r4 → busy_cnt=2.
  - Write r3 → r_busy(r3) drops, busy_cnt=1.
  - Reserve r3 and write r3 in the same cycle → r3 stays busy with the new data, busy_cnt=2.
- Counter edges:
  - reserve all 31 non-zero registers → busy_cnt=31.
  - Re-reserve r9 → busy_cnt stays 31.
  - Write all 31 → busy_cnt=0.
- Randomised, 10k cycles: compare r_data, r_busy and busy_cnt against a reference model under random rd/wr/rsv traffic.
